// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and execute-stage FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_BRCH = 4'b0111;
    localparam logic [3:0] ALU_JAL  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True for the two ops that may take the multi-cycle shift path.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit-per-cycle logical shifter (left or right).
// Latency: shamt cycles after start; done is high during the final shift cycle.
// Backpressure: none; the owning FSM only starts it when idle and waits for done.
module alu_serial_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   dir_right,
    input  logic [DATA_WIDTH-1:0]  load_val,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  shift_val
);

    logic [DATA_WIDTH-1:0]  acc;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   dir_q;

    // Value the accumulator takes on the next shift; also the final result when done.
    assign shift_val = dir_q ? {1'b0, acc[DATA_WIDTH-1:1]} : {acc[DATA_WIDTH-2:0], 1'b0};
    assign done      = (cnt == SHAMT_WIDTH'(1));

    // Load on start, then shift one bit and count down until the counter empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else if (start) begin
            acc   <= load_val;
            cnt   <= shamt;
            dir_q <= dir_right;
        end else if (cnt != '0) begin
            acc <= shift_val;
            cnt <= cnt - SHAMT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result and zero flag; ALU_EXEC_BARREL_SHIFT_EN selects a one-cycle barrel shifter.
// Latency: 1 cycle for all ops; SLL/SRL take shamt cycles on the iterative shifter (shamt==0 takes 1).
// Backpressure: ready_o drops while shifting or while a result is held with ready_i low.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            alu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  busy_o
);

    logic                   accept;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  op_result;
    logic                   write_res;
    logic [DATA_WIDTH-1:0]  wr_val;

    assign shamt  = b_i[SHAMT_WIDTH-1:0];
    assign accept = valid_i && ready_o;

    // Single-cycle datapath for the op presented at the input.
    always_comb begin
        op_result = '0;
        case (alu_operation_i)
            ALU_ADD:  op_result = a_i + b_i;
            ALU_SUB:  op_result = a_i - b_i;
            ALU_XOR:  op_result = a_i ^ b_i;
            ALU_OR:   op_result = a_i | b_i;
            ALU_AND:  op_result = a_i & b_i;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            ALU_SLL:  op_result = a_i << shamt;
            ALU_SRL:  op_result = a_i >> shamt;
`else
            // Only reached with shamt==0; nonzero amounts go through the serial shifter.
            ALU_SLL,
            ALU_SRL:  op_result = a_i;
`endif
            ALU_BRCH: op_result = a_i - b_i;
            ALU_JAL:  op_result = a_i + DATA_WIDTH'(4);
            ALU_LUI:  op_result = b_i;
            default:  op_result = '0;
        endcase
    end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    assign busy_o  = 1'b0;
    assign ready_o = !valid_o || ready_i;

    // Every accepted op writes its result on the accept edge.
    always_comb begin
        write_res = accept;
        wr_val    = op_result;
    end
`else
    state_t                state_q;
    state_t                state_d;
    logic                  start_shift;
    logic                  shift_done;
    logic [DATA_WIDTH-1:0] shift_val;

    alu_serial_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .start     (start_shift),
        .dir_right (alu_operation_i == ALU_SRL),
        .load_val  (a_i),
        .shamt     (shamt),
        .done      (shift_done),
        .shift_val (shift_val)
    );

    assign busy_o  = (state_q == ST_SHIFT);
    assign ready_o = (state_q == ST_IDLE) && (!valid_o || ready_i);

    // State register; reset abandons any shift in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, shifter start and result write selection.
    always_comb begin
        state_d     = state_q;
        start_shift = 1'b0;
        write_res   = 1'b0;
        wr_val      = op_result;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift_op(alu_operation_i) && (shamt != '0)) begin
                        start_shift = 1'b1;
                        state_d     = ST_SHIFT;
                    end else begin
                        write_res = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    write_res = 1'b1;
                    wr_val    = shift_val;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`endif

    // Output register: a new result written on the same edge as a consume wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
        end else if (write_res) begin
            valid_o  <= 1'b1;
            result_o <= wr_val;
            zero_o   <= (wr_val == '0);
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops, latency, backpressure and reset-mid-shift.
// Latency: checked per op against hand-derived edge counts.
// Backpressure: exercised by holding ready_i low over a held result.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  alu_operation_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        busy_o;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;
    int    n_checks = 0;
    int    n_pass   = 0;

    alu_exec_unit dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .result_o        (result_o),
        .zero_o          (zero_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every transfer (valid_o && ready_i) is compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got %h expected none", result_o);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                check({mon_n, "_res"}, result_o, mon_e.res);
                check({mon_n, "_zero"}, {31'd0, zero_o}, {31'd0, mon_e.z});
            end
        end
    end

    // Present one op, wait (bounded) for accept, then scramble inputs to prove capture.
    task automatic send(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit push);
        int w;
        exp_t e;
        w = 0;
        valid_i = 1'b1;
        alu_operation_i = op;
        a_i = a;
        b_i = b;
        @(negedge clk);
        while (!ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_checks++;
            $display("FAIL %s_accept: got ready_o=0 expected accept within 200 cycles", name);
        end
        if (push) begin
            e.res = exp;
            e.z   = (exp == 32'd0);
            exp_q.push_back(e);
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        alu_operation_i = 4'($urandom);
        a_i = $urandom;
        b_i = $urandom;
    endtask

    // Count edges from accept until valid_o; shifts must hold ready_o low and show busy_o.
    task automatic measure(input string name, input int exp_edges);
        int n;
        bit rdy_seen;
        bit busy_seen;
        n = 0;
        rdy_seen = 0;
        busy_seen = 0;
        while (!valid_o && n < 200) begin
            if (ready_o) rdy_seen = 1;
            if (busy_o) busy_seen = 1;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, exp_edges);
        check({name, "_busy_end"}, {31'd0, busy_o}, 32'd0);
        if (exp_edges > 0) begin
            check({name, "_ready_low"}, {31'd0, rdy_seen}, 32'd0);
            check({name, "_busy_seen"}, {31'd0, busy_seen}, 32'd1);
        end
    endtask

    initial begin
        int w;
        bit seen;
        reset = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        alu_operation_i = 4'd0;
        a_i = '0;
        b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

`ifndef ALU_EXEC_BARREL_SHIFT_EN
        // Reset three cycles into SLL shamt=10: the op must vanish.
        send("sll_abort", 4'b0101, 32'h1, 32'd10, 32'h0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy_before", {31'd0, busy_o}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", {31'd0, valid_o}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_result", result_o, 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1;
        end
        check("abort_no_result", {31'd0, seen}, 32'd0);
`endif

        send("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
        measure("add_wrap", 0);
        send("sub", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1);
        measure("sub", 0);

`ifdef ALU_EXEC_BARREL_SHIFT_EN
        send("sll3", 4'b0101, 32'h1, 32'h23, 32'h8, 1'b1);
        measure("sll3", 0);
        send("srl31", 4'b0110, 32'h8000_0000, 32'd31, 32'h1, 1'b1);
        measure("srl31", 0);
        send("srl4", 4'b0110, 32'hF0, 32'd4, 32'hF, 1'b1);
        measure("srl4", 0);
`else
        send("sll3", 4'b0101, 32'h1, 32'h23, 32'h8, 1'b1);
        measure("sll3", 3);
        send("srl31", 4'b0110, 32'h8000_0000, 32'd31, 32'h1, 1'b1);
        measure("srl31", 31);
        send("srl4", 4'b0110, 32'hF0, 32'd4, 32'hF, 1'b1);
        measure("srl4", 4);
`endif
        send("srl0", 4'b0110, 32'h55, 32'h20, 32'h55, 1'b1);
        measure("srl0", 0);

        // Let the last result drain before applying backpressure.
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        send("and_hold", 4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b1);
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_result", result_o, 32'h0000_F000);
            check("hold_ready", {31'd0, ready_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        send("or_replace", 4'b0011, 32'h0F, 32'hF0, 32'hFF, 1'b1);
        check("replace_valid", {31'd0, valid_o}, 32'd1);

        send("xor", 4'b0010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b1);
        send("brch_eq", 4'b0111, 32'h1234, 32'h1234, 32'h0, 1'b1);
        send("jal", 4'b1000, 32'h400, 32'hDEAD_BEEF, 32'h404, 1'b1);
        send("lui", 4'b1111, 32'h1, 32'hABCD_E000, 32'hABCD_E000, 1'b1);
        send("illegal", 4'b1010, 32'h5, 32'h6, 32'h0, 1'b1);

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_pending", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Performs the selected operation on two DATA_WIDTH operands and registers the result and zero flag.
- Valid/ready handshakes on input and output; SLL/SRL run on an iterative 1-bit-per-cycle shifter, so the stage can stall upstream issue.
- Sits between the operand-select muxes (upstream) and the writeback/branch logic (downstream).

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from operand B, equal to log2(DATA_WIDTH).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- valid_i  input  1  operation and operands are presented.
- ready_o  output  1  unit can accept this cycle.
- alu_operation_i  input  4  operation code from the ALU control decoder.
- a_i  input  DATA_WIDTH  operand A (rs1 or PC).
- b_i  input  DATA_WIDTH  operand B (rs2 or immediate).
- valid_o  output  1  result_o and zero_o are valid.
- ready_i  input  1  downstream consumes the result.
- result_o  output  DATA_WIDTH  registered result.
- zero_o  output  1  registered flag: (result == 0).
- busy_o  output  1  shift is in progress.

Behaviour:
- Reset, sampled on the clk edge: state IDLE, valid_o=0, result_o=0, zero_o=0, busy_o=0, shift counter=0. Reset mid-shift abandons the operation and produces no result.
- Opcodes: 0000 ADD a+b; 0001 SUB a-b; 0010 XOR; 0011 OR; 0100 AND; 0101 SLL a<<shamt; 0110 SRL a>>shamt (logical); 0111 BRCH a-b (zero_o reports equality); 1000 JAL a+4; 1111 LUI passes b. Any other code gives result 0 with single-cycle timing.
- Arithmetic is modulo 2^DATA_WIDTH; carry and overflow are discarded.
- shamt = b_i[SHAMT_WIDTH-1:0]; upper bits of b are ignored for shifts.
- ready_o = (state==IDLE) && (!valid_o || ready_i).
- Accept when valid_i && ready_o. Inputs are captured at accept; later input changes have no effect.
- States:
  - IDLE: on accepting a non-shift op, or a shift with shamt==0, write result_o/zero_o and set valid_o at the same edge. Latency is 1 cycle. State stays IDLE.
  - IDLE → SHIFT: on accepting a shift with shamt>0, load accumulator=a, counter=shamt, direction. busy_o=1.
  - SHIFT: each edge shifts the accumulator one bit and decrements the counter. On the edge where counter==1, write the shifted value to result_o, set valid_o, return to IDLE. Shift latency = shamt cycles (31 max at default width).
- Output handshake:
  - valid_o clears on an edge with valid_o && ready_i unless a new result is written on that same edge; a new result wins.
  - result_o and zero_o are held stable while valid_o && !ready_i.
- Back-to-back single-cycle ops with ready_i tied high: one accept per cycle, full throughput.
- While in SHIFT, ready_o=0 regardless of ready_i. A pending unconsumed result from an earlier op remains held.

Optional Feature:
- Macro: ALU_EXEC_BARREL_SHIFT_EN.
- Defined: SLL/SRL are computed combinationally with 1-cycle latency, like every other op. The SHIFT state and counter are not instantiated; busy_o is tied to 0.
- Undefined: iterative shifter as specified above.

Decomposition:
- Shared package alu_pkg: the 4-bit opcode constants (ADD, SUB, XOR, OR, AND, SLL, SRL, BRCH, JAL, LUI) used by the ALU control decoder and this unit, plus FSM state encodings IDLE/SHIFT.
- One sub-module: alu_serial_shifter. It holds the accumulator, counter, direction and done pulse, and is compiled out under ALU_EXEC_BARREL_SHIFT_EN.

Test Plan:
- Reset asserted while SHIFT is 3 cycles into SLL shamt=10 → next edge valid_o=0, busy_o=0, ready_o=1, result_o=0; no result is ever emitted for that op.
- ADD a=0xFFFFFFFF b=1, ready_i=1 → valid_o one cycle later, result_o=0, zero_o=1; SUB a=5 b=7 → 0xFFFFFFFE, zero_o=0.
- SLL a=0x1 b=0x23 (shamt=3) → ready_o=0 for 3 cycles, valid_o on the 3rd edge, result_o=0x8. SRL a=0x80000000 shamt=31 → result_o=0x1 after 31 cycles.
- ready_i held 0 after an AND result → result_o stable and ready_o=0 for 5 cycles. Raising ready_i with valid_i high → the old result is consumed and the new one is written on the same edge.
- BRCH a=b=0x1234 → zero_o=1; JAL a=0x400 → result_o=0x404; LUI b=0xABCDE000 → result_o=0xABCDE000; opcode 1010 → result_o=0, zero_o=1.
- With ALU_EXEC_BARREL_SHIFT_EN: SRL a=0xF0 shamt=4 → result_o=0xF, latency 1, busy_o never asserted.
